coherence_ctrl: RTL and testbench

COHERENCE_CTRL -- requirements
Module: coherence_ctrl

---
 rtl/coherence_ctrl.sv | 155 +++++++++++++++
 tb/tb_coherence_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/coherence_ctrl.sv
// Two-cache snooping coherence controller sharing one RAM port.
// One transaction at a time; requests are arbitrated round-robin and served by the snooper or by RAM.
module coherence_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [31:0] daddr [0:1],
  input  logic [31:0] dstore [0:1],
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  output logic [1:0]  dwait,
  output logic [31:0] dload [0:1],
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr [0:1],
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramwait
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    FWD   = 3'd2,
    LOAD  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  logic       req;
  logic       rr;
  logic       inv;
  logic       snp;
  logic [1:0] cand;
  logic       grant;
  logic       abort;

  assign snp = ~req;

  // Arbitration and protocol-violation detection for the current requester.
  always_comb begin
    cand  = dREN | dWEN;
    grant = (cand == 2'b11) ? rr : cand[1];
    if (state != IDLE) begin
      abort = ~(dREN[req] | dWEN[req]);
    end else begin
      abort = 1'b0;
    end
  end

  // Transaction sequencing, requester capture, round-robin pointer and invalidate latch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      req   <= 1'b0;
      rr    <= 1'b0;
      inv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            req   <= grant;
            state <= dWEN[grant] ? WRITE : SNOOP;
          end
        end
        SNOOP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            inv   <= ccwrite[req];
            state <= (cctrans[snp] & ccwrite[snp]) ? FWD : LOAD;
          end
        end
        FWD, LOAD, WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else if (!ramwait) begin
            state <= IDLE;
            rr    <= ~req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; completion handshakes follow ramwait within the same cycle.
  always_comb begin
    dwait          = 2'b11;
    dload[0]       = 32'h0000_0000;
    dload[1]       = 32'h0000_0000;
    ccwait         = 2'b00;
    ccinv          = 2'b00;
    ccsnoopaddr[0] = 32'h0000_0000;
    ccsnoopaddr[1] = 32'h0000_0000;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = 32'h0000_0000;
    ramstore       = 32'h0000_0000;
    if (!abort) begin
      case (state)
        SNOOP: begin
          ccwait[snp]      = 1'b1;
          ccsnoopaddr[snp] = daddr[req];
          ccinv[snp]       = ccwrite[req];
        end
        FWD: begin
          ccwait[snp]      = 1'b1;
          ccinv[snp]       = inv;
          ccsnoopaddr[snp] = daddr[req];
          ramWEN           = 1'b1;
          ramaddr          = daddr[req];
          ramstore         = dstore[snp];
          dload[req]       = dstore[snp];
          if (!ramwait) begin
            dwait = 2'b00;
          end else begin
            dwait = 2'b11;
          end
        end
        LOAD: begin
          ccwait[snp]      = 1'b1;
          ccinv[snp]       = inv;
          ccsnoopaddr[snp] = daddr[req];
          ramREN           = 1'b1;
          ramaddr          = daddr[req];
          dload[req]       = ramload;
          if (!ramwait) begin
            dwait[req] = 1'b0;
          end else begin
            dwait[req] = 1'b1;
          end
        end
        WRITE: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[req];
          ramstore = dstore[req];
          if (!ramwait) begin
            dwait[req] = 1'b0;
          end else begin
            dwait[req] = 1'b1;
          end
        end
        default: dwait = 2'b11;
      endcase
    end else begin
      dwait = 2'b11;
    end
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed self-checking bench for coherence_ctrl: inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_coherence_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  dREN;
  logic [1:0]  dWEN;
  logic [31:0] daddr [0:1];
  logic [31:0] dstore [0:1];
  logic [1:0]  cctrans;
  logic [1:0]  ccwrite;
  logic [1:0]  dwait;
  logic [31:0] dload [0:1];
  logic [1:0]  ccwait;
  logic [1:0]  ccinv;
  logic [31:0] ccsnoopaddr [0:1];
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramwait;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp2;
  logic [31:0] exp_addr;

  coherence_ctrl dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
    daddr[0] = 32'h0; daddr[1] = 32'h0; dstore[0] = 32'h0; dstore[1] = 32'h0;
    ramload = 32'h0; ramwait = 1'b1;
    @(negedge CLK); @(negedge CLK); #1;
    chk("rst_dwait", {30'd0, dwait}, 32'd3);
    chk("rst_ccwait", {30'd0, ccwait}, 32'd0);
    chk("rst_ccinv", {30'd0, ccinv}, 32'd0);
    chk("rst_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_dload0", dload[0], 32'h0);

    // Clean miss served from RAM after two wait cycles
    @(negedge CLK);
    RST = 1'b0; dREN = 2'b01; daddr[0] = 32'h100; ramload = 32'hDEADBEEF; ramwait = 1'b1;
    #1 chk("t1_idle_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK);
    cctrans = 2'b10;
    #1;
    chk("t1_snoop_ccwait", {30'd0, ccwait}, 32'd2);
    chk("t1_snoop_addr", ccsnoopaddr[1], 32'h100);
    chk("t1_snoop_ccinv", {30'd0, ccinv}, 32'd0);
    chk("t1_snoop_ram", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("t1_snoop_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK); #1;
    chk("t1_load_ramren", {31'd0, ramREN}, 32'd1);
    chk("t1_load_ramaddr", ramaddr, 32'h100);
    chk("t1_load_dload", dload[0], 32'hDEADBEEF);
    chk("t1_load_dwait_busy", {30'd0, dwait}, 32'd3);
    chk("t1_load_snoopaddr", ccsnoopaddr[1], 32'h100);
    @(negedge CLK); #1;
    chk("t1_load_dwait_busy2", {30'd0, dwait}, 32'd3);
    @(negedge CLK);
    ramwait = 1'b0;
    #1;
    chk("t1_done_dwait", {30'd0, dwait}, 32'd2);
    chk("t1_done_dload", dload[0], 32'hDEADBEEF);
    @(negedge CLK);
    dREN = 2'b00; cctrans = 2'b00; ramwait = 1'b1;
    #1;
    chk("t1_after_dwait", {30'd0, dwait}, 32'd3);
    chk("t1_after_snoopaddr", ccsnoopaddr[1], 32'h0);
    chk("t1_after_dload", dload[0], 32'h0);

    // Write-intent miss supplied by the dirty snooper
    @(negedge CLK);
    dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h200;
    dstore[0] = 32'h12345678; dstore[1] = 32'h0BAD0BAD;
    #1 chk("t2_idle_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK);
    cctrans = 2'b11; ccwrite = 2'b11;
    #1;
    chk("t2_snoop_ccwait", {30'd0, ccwait}, 32'd1);
    chk("t2_snoop_ccinv", {30'd0, ccinv}, 32'd1);
    chk("t2_snoop_addr", ccsnoopaddr[0], 32'h200);
    @(negedge CLK);
    ccwrite = 2'b01;
    #1;
    chk("t2_fwd_ccinv_held", {30'd0, ccinv}, 32'd1);
    chk("t2_fwd_ccwait", {30'd0, ccwait}, 32'd1);
    chk("t2_fwd_dload", dload[1], 32'h12345678);
    chk("t2_fwd_ram_en", {30'd0, ramREN, ramWEN}, 32'd1);
    chk("t2_fwd_ramstore", ramstore, 32'h12345678);
    chk("t2_fwd_ramaddr", ramaddr, 32'h200);
    chk("t2_fwd_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK);
    ramwait = 1'b0;
    #1;
    chk("t2_done_dwait", {30'd0, dwait}, 32'd0);
    chk("t2_done_ram_en", {30'd0, ramREN, ramWEN}, 32'd1);
    @(negedge CLK);
    dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00; ramwait = 1'b1;
    #1;
    chk("t2_after_dwait", {30'd0, dwait}, 32'd3);
    chk("t2_after_dload", dload[1], 32'h0);

    // Simultaneous writebacks after reset: cache0 then cache1, pointer back at 0
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; dWEN = 2'b11; ramwait = 1'b0;
    daddr[0] = 32'h300; dstore[0] = 32'hA0A0A0A0; daddr[1] = 32'h400; dstore[1] = 32'hB0B0B0B0;
    #1 chk("t3_idle_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK); #1;
    chk("t3_w0_ramwen", {30'd0, ramREN, ramWEN}, 32'd1);
    chk("t3_w0_ramaddr", ramaddr, 32'h300);
    chk("t3_w0_ramstore", ramstore, 32'hA0A0A0A0);
    chk("t3_w0_dwait", {30'd0, dwait}, 32'd2);
    @(negedge CLK);
    dWEN = 2'b10;
    #1;
    chk("t3_gap_dwait", {30'd0, dwait}, 32'd3);
    chk("t3_gap_ramwen", {31'd0, ramWEN}, 32'd0);
    @(negedge CLK); #1;
    chk("t3_w1_ramaddr", ramaddr, 32'h400);
    chk("t3_w1_ramstore", ramstore, 32'hB0B0B0B0);
    chk("t3_w1_dwait", {30'd0, dwait}, 32'd1);
    @(negedge CLK);
    dWEN = 2'b11;
    #1 chk("t3_gap2_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK); #1;
    chk("t3_rr_ends_0", ramaddr, 32'h300);
    chk("t3_rr_ends_0_dwait", {30'd0, dwait}, 32'd2);
    @(negedge CLK);
    dWEN = 2'b00; ramwait = 1'b1;

    // Back-to-back reads from both caches alternate grants
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; dREN = 2'b11; ramwait = 1'b0; cctrans = 2'b00; ccwrite = 2'b00;
    daddr[0] = 32'h500; daddr[1] = 32'h600; ramload = 32'h00005A5A;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK); #1;
      exp2 = (t % 2 == 0) ? 2'b10 : 2'b01;
      chk("t4_grant_ccwait", {30'd0, ccwait}, {30'd0, exp2});
      @(negedge CLK); #1;
      exp2 = (t % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (t % 2 == 0) ? 32'h500 : 32'h600;
      chk("t4_done_dwait", {30'd0, dwait}, {30'd0, exp2});
      chk("t4_done_ramaddr", ramaddr, exp_addr);
      @(negedge CLK); #1;
      chk("t4_idle_dwait", {30'd0, dwait}, 32'd3);
    end

    // Reset in the middle of a stalled RAM load
    @(negedge CLK);
    RST = 1'b1; dREN = 2'b00;
    @(negedge CLK);
    RST = 1'b0; dREN = 2'b01; daddr[0] = 32'h700; ramwait = 1'b1; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("t5_load_ramren", {31'd0, ramREN}, 32'd1);
    RST = 1'b1;
    #1;
    chk("t5_rst_ramren", {31'd0, ramREN}, 32'd0);
    chk("t5_rst_dwait", {30'd0, dwait}, 32'd3);
    chk("t5_rst_ccwait", {30'd0, ccwait}, 32'd0);
    chk("t5_rst_ramaddr", ramaddr, 32'h0);
    chk("t5_rst_dload", dload[0], 32'h0);
    chk("t5_rst_snoopaddr", ccsnoopaddr[1], 32'h0);
    @(negedge CLK); #1;
    chk("t5_rst_hold_ramren", {31'd0, ramREN}, 32'd0);
    chk("t5_rst_hold_dwait", {30'd0, dwait}, 32'd3);

    // Requester drops a pending writeback: abort, no write, pointer unchanged
    @(negedge CLK);
    RST = 1'b0; dREN = 2'b00; dWEN = 2'b01; daddr[0] = 32'h800; dstore[0] = 32'h11112222; ramwait = 1'b1;
    @(negedge CLK); #1;
    chk("t6_write_ramwen", {31'd0, ramWEN}, 32'd1);
    dWEN = 2'b00;
    #1;
    chk("t6_abort_no_write", {31'd0, ramWEN}, 32'd0);
    chk("t6_abort_dwait", {30'd0, dwait}, 32'd3);
    @(negedge CLK);
    dREN = 2'b11; cctrans = 2'b00;
    #1;
    chk("t6_idle_ccwait", {30'd0, ccwait}, 32'd0);
    @(negedge CLK); #1;
    chk("t6_abort_rr_kept", {30'd0, ccwait}, 32'd2);
    @(negedge CLK);
    dREN = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
